// File: rtl/processor_ci_mem_pkg.sv
// ============================================================================
// Module      : processor_ci_mem_pkg
// Description : Shared types and constants for the processor-ci memory
//               arbiter: FSM states, owner encoding and latency limits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package processor_ci_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam logic OWNER_CTRL       = 1'b0;
    localparam logic OWNER_CORE       = 1'b1;

    localparam int   MAX_READ_LATENCY = 7;
    localparam int   LAT_CNT_WIDTH    = 3;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module      : memory_arbiter
// Description : Serialises single-word accesses from the controller and the
//               core onto one memory port. Tie policy selected by the macro
//               MEMORY_ARBITER_ROUND_ROBIN_EN (defined: alternate, else the
//               controller wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter
    import processor_ci_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ctrl_read,
    input  logic                  ctrl_write,
    input  logic [ADDR_WIDTH-1:0] ctrl_address,
    input  logic [DATA_WIDTH-1:0] ctrl_write_data,
    output logic [DATA_WIDTH-1:0] ctrl_read_data,
    output logic                  ctrl_ack,

    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [ADDR_WIDTH-1:0] core_address,
    input  logic [DATA_WIDTH-1:0] core_write_data,
    output logic [DATA_WIDTH-1:0] core_read_data,
    output logic                  core_ack,

    output logic                  memory_read_memory,
    output logic                  memory_write_memory,
    output logic [ADDR_WIDTH-1:0] address_memory,
    output logic [DATA_WIDTH-1:0] write_data_memory,
    input  logic [DATA_WIDTH-1:0] read_data_memory,

    output logic                  owner
);

    localparam logic [LAT_CNT_WIDTH-1:0] c_read_latency = LAT_CNT_WIDTH'(READ_LATENCY);
    localparam logic [LAT_CNT_WIDTH-1:0] c_lat_one      = LAT_CNT_WIDTH'(1);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_read_latency
            $error("memory_arbiter: READ_LATENCY must be within 1..%0d", MAX_READ_LATENCY);
        end
    endgenerate

    arb_state_t               r_state;
    arb_state_t               w_next_state;
    logic [LAT_CNT_WIDTH-1:0] r_lat_cnt;
    logic                     r_owner;
    logic                     r_is_write;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_ctrl_rdata;
    logic [DATA_WIDTH-1:0]    r_core_rdata;

    logic                     w_ctrl_req;
    logic                     w_core_req;
    logic                     w_any_req;
    logic                     w_tie_pick;
    logic                     w_grant;
    logic                     w_last_wait;

    assign w_ctrl_req  = ctrl_read | ctrl_write;
    assign w_core_req  = core_read | core_write;
    assign w_any_req   = w_ctrl_req | w_core_req;
    assign w_last_wait = (r_lat_cnt == c_read_latency);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // Tie goes to whichever side did not hold the port last.
    assign w_tie_pick = ~r_owner;
`else
    assign w_tie_pick = OWNER_CTRL;
`endif

    assign w_grant = (w_ctrl_req && w_core_req) ? w_tie_pick :
                     (w_core_req ? OWNER_CORE : OWNER_CTRL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ISSUE;
            ISSUE:   w_next_state = r_is_write ? ACK : WAIT;
            WAIT:    if (w_last_wait) w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWNER_CTRL;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= '0;
            r_ctrl_rdata <= '0;
            r_core_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_owner <= w_grant;
                // A write takes precedence when read and write are both high.
                if (w_grant == OWNER_CORE) begin
                    r_addr     <= core_address;
                    r_wdata    <= core_write_data;
                    r_is_write <= core_write;
                end else begin
                    r_addr     <= ctrl_address;
                    r_wdata    <= ctrl_write_data;
                    r_is_write <= ctrl_write;
                end
            end

            if (r_state == ISSUE) begin
                r_lat_cnt <= c_lat_one;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt + c_lat_one;
            end

            if (r_state == WAIT && w_last_wait) begin
                if (r_owner == OWNER_CORE) begin
                    r_core_rdata <= read_data_memory;
                end else begin
                    r_ctrl_rdata <= read_data_memory;
                end
            end
        end
    end

    assign memory_read_memory  = (r_state == ISSUE) && !r_is_write;
    assign memory_write_memory = (r_state == ISSUE) &&  r_is_write;
    assign address_memory      = r_addr;
    assign write_data_memory   = r_wdata;
    assign ctrl_ack            = (r_state == ACK) && (r_owner == OWNER_CTRL);
    assign core_ack            = (r_state == ACK) && (r_owner == OWNER_CORE);
    assign ctrl_read_data      = r_ctrl_rdata;
    assign core_read_data      = r_core_rdata;
    assign owner               = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter against a cycle-level
//               transaction model and a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_read, ctrl_write, ctrl_ack;
    logic [31:0] ctrl_address, ctrl_write_data, ctrl_read_data;
    logic        core_read, core_write, core_ack;
    logic [31:0] core_address, core_write_data, core_read_data;
    logic        memory_read_memory, memory_write_memory;
    logic [31:0] address_memory, write_data_memory;
    logic [31:0] read_data_memory = '0;
    logic        owner;

    int errors = 0;
    int checks = 0;

    memory_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .READ_LATENCY (L)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ctrl_read           (ctrl_read),
        .ctrl_write          (ctrl_write),
        .ctrl_address        (ctrl_address),
        .ctrl_write_data     (ctrl_write_data),
        .ctrl_read_data      (ctrl_read_data),
        .ctrl_ack            (ctrl_ack),
        .core_read           (core_read),
        .core_write          (core_write),
        .core_address        (core_address),
        .core_write_data     (core_write_data),
        .core_read_data      (core_read_data),
        .core_ack            (core_ack),
        .memory_read_memory  (memory_read_memory),
        .memory_write_memory (memory_write_memory),
        .address_memory      (address_memory),
        .write_data_memory   (write_data_memory),
        .read_data_memory    (read_data_memory),
        .owner               (owner)
    );

    always #5 clk = ~clk;

    // Behavioural memory: words written on write strobes, read data presented
    // only in the cycle L after a read strobe, noise otherwise.
    logic [31:0] mem [logic [31:0]];
    int          cyc = 0;
    int          pend_due = -1;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == 32'h20) return 32'h1234_5678;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (cyc == pend_due) read_data_memory = mem_val(pend_addr);
        else                 read_data_memory = $urandom;
        if (memory_write_memory) mem[address_memory] = write_data_memory;
        if (memory_read_memory) begin
            pend_addr = address_memory;
            pend_due  = cyc + L;
        end
    end

    // Model state: last granted side and each side's expected read register.
    bit          m_owner = 1'b0;
    logic [31:0] exp_rdata [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int tie_winner(input bit last);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        return last ? 0 : 1;
`else
        return (last === 1'bx) ? 1 : 0;
`endif
    endfunction

    function automatic logic [63:0] ev_obs();
        return 64'({memory_read_memory, memory_write_memory, ctrl_ack, core_ack});
    endfunction

    task automatic drop(input int p);
        if (p == 0) begin ctrl_read = 1'b0; ctrl_write = 1'b0; end
        else        begin core_read = 1'b0; core_write = 1'b0; end
    endtask

    task automatic check_rdata();
        check("ctrl_read_data", 64'(ctrl_read_data), 64'(exp_rdata[0]));
        check("core_read_data", 64'(core_read_data), 64'(exp_rdata[1]));
    endtask

    // Called just after a negedge with the DUT idle; returns the same way.
    task automatic run_pair(input bit en0, input bit rd0, input bit wr0,
                            input logic [31:0] a0, input logic [31:0] d0,
                            input bit en1, input bit rd1, input bit wr1,
                            input logic [31:0] a1, input logic [31:0] d1);
        bit          en  [2];
        bit          isw [2];
        logic [31:0] ad  [2];
        logic [31:0] dd  [2];
        logic [31:0] rv  [2];
        int          dur [2];
        int          stb [2];
        int          ackc[2];
        int          first, second, last;
        logic [3:0]  ev;
        en[0] = en0; en[1] = en1;
        isw[0] = wr0; isw[1] = wr1;
        ad[0] = a0; ad[1] = a1; dd[0] = d0; dd[1] = d1;
        rv[0] = '0; rv[1] = '0;
        ctrl_read = rd0 & en0; ctrl_write = wr0 & en0;
        ctrl_address = a0; ctrl_write_data = d0;
        core_read = rd1 & en1; core_write = wr1 & en1;
        core_address = a1; core_write_data = d1;
        for (int p = 0; p < 2; p++) dur[p] = isw[p] ? 2 : 2 + L;
        if (en0 && en1) first = tie_winner(m_owner);
        else            first = en1 ? 1 : 0;
        second = 1 - first;
        stb[first]  = 1;
        ackc[first] = dur[first];
        if (en[second]) begin
            stb[second]  = dur[first] + 2;
            ackc[second] = dur[first] + 1 + dur[second];
            last = ackc[second];
        end else begin
            stb[second]  = -1;
            ackc[second] = -1;
            last = ackc[first];
        end
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            ev = '0;
            for (int p = 0; p < 2; p++) begin
                if (n == stb[p])  ev[isw[p] ? 2 : 3] = 1'b1;
                if (n == ackc[p]) ev[p == 0 ? 1 : 0] = 1'b1;
            end
            check("strobe_ack", ev_obs(), 64'(ev));
            for (int p = 0; p < 2; p++) begin
                if (n == stb[p]) begin
                    check("owner_grant", 64'(owner), 64'(p));
                    check("address_memory", 64'(address_memory), 64'(ad[p]));
                    check("write_data_memory", 64'(write_data_memory), 64'(dd[p]));
                    rv[p] = mem_val(ad[p]);
                end
                if (n == ackc[p]) begin
                    if (!isw[p]) exp_rdata[p] = rv[p];
                    drop(p);
                    check_rdata();
                end
            end
        end
        @(negedge clk);
        check("idle_quiet", ev_obs(), 64'(0));
        m_owner = en[second] ? second[0] : first[0];
        check("owner_last", 64'(owner), 64'(m_owner));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, a1, d0, d1;
        int          op0, op1, sel;
        bit          r0, w0, r1, w1;
        int          per;
        logic [3:0]  ev;

        reset = 1'b1;
        ctrl_read = 0; ctrl_write = 0; ctrl_address = '0; ctrl_write_data = '0;
        core_read = 0; core_write = 0; core_address = '0; core_write_data = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({memory_read_memory, memory_write_memory, ctrl_ack, core_ack, owner}), 64'(0));
        check("reset_addr", 64'(address_memory), 64'(0));
        check("reset_wdata", 64'(write_data_memory), 64'(0));
        check_rdata();
        reset = 1'b0;
        @(negedge clk);

        // Controller write
        run_pair(1, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, '0, '0);
        // Two successive ties
        run_pair(1, 1, 0, 32'h44, 32'h1111_1111, 1, 0, 1, 32'h48, 32'h2222_2222);
        run_pair(1, 0, 1, 32'h4C, 32'h3333_3333, 1, 1, 0, 32'h44, 32'h4444_4444);
        // Core read with preset memory word
        run_pair(0, 0, 0, '0, '0, 1, 1, 0, 32'h20, 32'h0);
        // Read and write both high on the controller
        run_pair(1, 1, 1, 32'h30, 32'hCAFE_F00D, 0, 0, 0, '0, '0);
        run_pair(1, 1, 0, 32'h30, 32'h0, 0, 0, 0, '0, '0);

        // Reset while a core read waits for data
        core_read = 1'b1; core_address = 32'h58; core_write_data = 32'h0;
        @(negedge clk);
        check("rst_pre_strobe", ev_obs(), 64'(4'b1000));
        @(negedge clk);
        reset = 1'b1;
        core_read = 1'b0;
        #1;
        check("rst_ctl", 64'({memory_read_memory, memory_write_memory, ctrl_ack, core_ack, owner}), 64'(0));
        check("rst_addr", 64'(address_memory), 64'(0));
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        m_owner = 1'b0;
        check_rdata();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_ack", ev_obs(), 64'(0));
        end
        run_pair(0, 0, 0, '0, '0, 1, 1, 0, 32'h58, 32'h0);

        // Core holds its read request across two accesses
        per = 3 + L;
        core_read = 1'b1; core_address = 32'h20;
        for (int n = 1; n <= 2 * per - 1; n++) begin
            @(negedge clk);
            ev = '0;
            if (n % per == 1)       ev[3] = 1'b1;
            if (n % per == per - 1) ev[0] = 1'b1;
            check("held_strobe_ack", ev_obs(), 64'(ev));
            if (n % per == per - 1) begin
                exp_rdata[1] = mem_val(32'h20);
                check_rdata();
            end
            if (n == 2 * per - 1) core_read = 1'b0;
        end
        @(negedge clk);
        check("held_quiet", ev_obs(), 64'(0));
        m_owner = 1'b1;

        // Randomised traffic
        for (int it = 0; it < 24; it++) begin
            sel = $urandom_range(1, 3);
            op0 = $urandom_range(0, 3);
            op1 = $urandom_range(0, 3);
            r0 = (op0 != 1); w0 = (op0 == 1 || op0 == 2);
            r1 = (op1 != 1); w1 = (op1 == 1 || op1 == 2);
            a0 = 32'($urandom_range(0, 15)) << 2;
            a1 = 32'($urandom_range(0, 15)) << 2;
            d0 = $urandom;
            d1 = $urandom;
            run_pair(sel[0], r0, w0, a0, d0, sel[1], r1, w1, a1, d1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
